// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the 5-stage LEGv8 pipeline. Issues sequential word fetches to
//   an in-order, variable-latency instruction memory, buffers the returned
//   words in a small prefetch FIFO, and loads the IF/ID register that feeds
//   InstructionDecode.
//
//   Memory handshake: a request transfers on a rising edge where
//   imem_req && imem_ready. While imem_req is high and not yet accepted,
//   imem_addr is held stable. The only exception is a redirect, which
//   withdraws the request in that cycle. Responses (imem_rvalid/imem_rdata)
//   return one per cycle, in request order, and cannot be back-pressured.
//   A credit rule keeps (FIFO entries + outstanding requests) <= FIFO_DEPTH,
//   so every response always has a FIFO slot.
//
// Ports
//   clk               clock, rising edge
//   reset             synchronous, active-high reset
//   stall_ID          hold the IF/ID register (hazard unit)
//   PCSrc_MEM         taken branch resolved in MEM: flush and redirect
//   BranchTarget_MEM  redirect target, used as given
//   imem_req          fetch request valid
//   imem_addr         fetch address
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid       response valid (in request order)
//   imem_rdata        fetched instruction word
//   instruction_ID    IF/ID instruction
//   pc_ID             IF/ID PC of that instruction
//   valid_ID          IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_ID,
    input  logic        PCSrc_MEM,
    input  logic [63:0] BranchTarget_MEM,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_ID,
    output logic [63:0] pc_ID,
    output logic        valid_ID
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [63:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];

    logic          accept;
    logic          drop_resp;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    always_comb begin
        occupancy = {1'b0, count} + {1'b0, out_cnt};
        imem_req  = !reset && !PCSrc_MEM && (occupancy < {1'b0, DEPTH_C});
        imem_addr = fetch_pc;
        accept    = imem_req && imem_ready;
        // A pending drop count marks responses that belong to a flushed path.
        drop_resp = imem_rvalid && (drop_cnt != '0);
        push      = imem_rvalid && (drop_cnt == '0) && !PCSrc_MEM && !reset;
        pop       = !PCSrc_MEM && !stall_ID && (count != '0);
    end

    // Fetch / response bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (PCSrc_MEM) begin
            // No request goes out this cycle, so out_cnt only loses a response
            // arriving now; everything still in flight is stale and dropped.
            fetch_pc <= BranchTarget_MEM;
            resp_pc  <= BranchTarget_MEM;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_cnt  <= out_cnt - CW'(imem_rvalid);
            drop_cnt <= out_cnt - CW'(imem_rvalid);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            out_cnt <= out_cnt + CW'(accept) - CW'(imem_rvalid);
            if (drop_resp) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 64'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Prefetch storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    // IF/ID register: flush beats stall; pc_ID holds across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction_ID <= '0;
            pc_ID          <= '0;
            valid_ID       <= 1'b0;
        end else if (PCSrc_MEM) begin
            instruction_ID <= '0;
            valid_ID       <= 1'b0;
        end else if (!stall_ID) begin
            if (count != '0) begin
                pc_ID          <= fifo_pc[rd_ptr];
                instruction_ID <= fifo_instr[rd_ptr];
                valid_ID       <= 1'b1;
            end else begin
                instruction_ID <= '0;
                valid_ID       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Bench for instruction_fetch. A behavioural memory returns addr[33:2] for
//   each accepted request after a per-request latency (in order). The
//   reference model treats the fetch path as a program-order stream: every
//   accepted address since the last reset/redirect must be delivered to IF/ID
//   exactly once, in order, and the fetcher may only request while the words
//   it owes (current-path words not yet delivered plus stale words still in
//   flight) are below FIFO_DEPTH.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        stall_ID;
  logic        PCSrc_MEM;
  logic [63:0] BranchTarget_MEM;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction_ID;
  logic [63:0] pc_ID;
  logic        valid_ID;

  instruction_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_ID         (stall_ID),
    .PCSrc_MEM        (PCSrc_MEM),
    .BranchTarget_MEM (BranchTarget_MEM),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instruction_ID   (instruction_ID),
    .pc_ID            (pc_ID),
    .valid_ID         (valid_ID)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check / report ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [63:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t mem_q[$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat_min = 1;
  int    lat_max = 1;
  bit    rand_ready = 0;
  bit    ready_low = 0;
  int    pres_ep = 0;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [63:0] iss_pc = 64'h0;
  int          stale_cnt = 0;
  int          epoch = 0;
  int          n_pop = 0;
  bit          prev_rst = 1'b1;
  bit          prev_flush = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] m_pc = 64'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_valid = 1'b0;

  // Edge-side bookkeeping: request accounting and accepted-address stream.
  always @(posedge clk) begin
    logic exp_req;
    int   lat;
    int   due;
    prev_rst   = reset;
    prev_flush = PCSrc_MEM;
    prev_stall = stall_ID;
    if (reset) begin
      check("req_in_reset", 64'(imem_req), 64'h0);
      mem_q.delete();
      exp_q.delete();
      stale_cnt = 0;
      epoch++;
      iss_pc = 64'h0;
      last_due = 0;
    end else begin
      exp_req = !PCSrc_MEM && ((exp_q.size() + stale_cnt) < DEPTH);
      check("req", 64'(imem_req), 64'(exp_req));
      if (imem_rvalid && pres_ep != epoch) stale_cnt--;
      if (PCSrc_MEM) begin
        stale_cnt = mem_q.size();
        exp_q.delete();
        epoch++;
        iss_pc = BranchTarget_MEM;
      end else if (imem_req && imem_ready) begin
        check("fetch_addr", imem_addr, iss_pc);
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{imem_addr, due, epoch});
        exp_q.push_back(iss_pc);
        iss_pc = iss_pc + 64'd4;
      end
    end
    cyc++;
  end

  // Memory drives ready/response shortly after the falling edge.
  always @(negedge clk) begin
    mreq_t r;
    #2;
    if (ready_low) imem_ready = 1'b0;
    else if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
    else imem_ready = 1'b1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = r.addr[33:2];
      pres_ep     = r.ep;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  // IF/ID monitor: outputs reflect the previous edge's inputs.
  always @(negedge clk) begin
    logic [63:0] e_pc;
    if (prev_rst) begin
      check("rst_valid", 64'(valid_ID), 64'h0);
      check("rst_pc", pc_ID, 64'h0);
      check("rst_instr", 64'(instruction_ID), 64'h0);
      m_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (prev_flush) begin
      check("flush_valid", 64'(valid_ID), 64'h0);
      check("flush_instr", 64'(instruction_ID), 64'h0);
      check("flush_pc_hold", pc_ID, m_pc);
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (prev_stall) begin
      check("stall_valid", 64'(valid_ID), 64'(m_valid));
      check("stall_pc", pc_ID, m_pc);
      check("stall_instr", 64'(instruction_ID), 64'(m_instr));
    end else if (valid_ID === 1'b1) begin
      check("pop_expected", 64'(exp_q.size() != 0), 64'h1);
      if (exp_q.size() != 0) begin
        e_pc = exp_q.pop_front();
        check("pop_pc", pc_ID, e_pc);
        check("pop_instr", 64'(instruction_ID), 64'(e_pc[33:2]));
        m_pc = e_pc; m_instr = e_pc[33:2]; m_valid = 1'b1;
        n_pop++;
      end
    end else begin
      check("bubble_valid", 64'(valid_ID), 64'h0);
      check("bubble_instr", 64'(instruction_ID), 64'h0);
      check("bubble_pc_hold", pc_ID, m_pc);
      m_instr = 32'h0; m_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    stall_ID = 1'b0;
    PCSrc_MEM = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_if(input string tag, input logic v, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(valid_ID), 64'(v));
    if (v) begin
      check({tag, "_pc"}, pc_ID, pc);
      check({tag, "_instr"}, 64'(instruction_ID), 64'(pc[33:2]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    stall_ID = 1'b0;
    PCSrc_MEM = 1'b0;
    BranchTarget_MEM = 64'h0;

    // Zero-wait streaming from reset, then a 6-cycle stall at pc 8.
    lat_min = 1; lat_max = 1;
    do_reset(2);
    #1;
    check("t1_req0", 64'(imem_req), 64'h1);
    check("t1_addr0", imem_addr, 64'h0);
    repeat (2) @(negedge clk);
    check("t1_latency", 64'(valid_ID), 64'h0);
    @(negedge clk); expect_if("t1_i0", 1'b1, 64'h0);
    @(negedge clk); expect_if("t1_i1", 1'b1, 64'h4);
    @(negedge clk); expect_if("t1_i2", 1'b1, 64'h8);
    stall_ID = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      expect_if("t2_hold", 1'b1, 64'h8);
    end
    #1 check("t2_full_req", 64'(imem_req), 64'h0);
    @(negedge clk);
    expect_if("t2_hold6", 1'b1, 64'h8);
    stall_ID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_if("t2_resume", 1'b1, 64'd12 + 64'(4 * k));
    end

    // Latency 3, two outstanding, redirect to 0x100.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    repeat (2) @(negedge clk);
    PCSrc_MEM = 1'b1;
    BranchTarget_MEM = 64'h100;
    #1 check("t3_req_withdrawn", 64'(imem_req), 64'h0);
    @(negedge clk);
    PCSrc_MEM = 1'b0;
    #1;
    check("t3_valid_flush", 64'(valid_ID), 64'h0);
    check("t3_req", 64'(imem_req), 64'h1);
    check("t3_addr", imem_addr, 64'h100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_stale_dropped", 64'(valid_ID), 64'h0);
    end
    @(negedge clk); expect_if("t3_first", 1'b1, 64'h100);

    // Latency 2: flush coincident with stall and a returning response.
    lat_min = 2; lat_max = 2;
    do_reset(1);
    repeat (5) @(negedge clk);
    expect_if("t4_pre", 1'b1, 64'h4);
    stall_ID = 1'b1;
    PCSrc_MEM = 1'b1;
    BranchTarget_MEM = 64'h200;
    @(negedge clk);
    stall_ID = 1'b0;
    PCSrc_MEM = 1'b0;
    #1;
    check("t4_flush_valid", 64'(valid_ID), 64'h0);
    check("t4_flush_instr", 64'(instruction_ID), 64'h0);
    check("t4_pc_hold", pc_ID, 64'h4);
    check("t4_addr", imem_addr, 64'h200);
    repeat (3) @(negedge clk);
    check("t4_gap", 64'(valid_ID), 64'h0);
    @(negedge clk); expect_if("t4_first", 1'b1, 64'h200);

    // Zero-wait, memory not ready for 5 cycles at 0x20.
    lat_min = 1; lat_max = 1;
    do_reset(1);
    repeat (8) @(negedge clk);
    ready_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_addr_stable", imem_addr, 64'h20);
      check("t5_req_high", 64'(imem_req), 64'h1);
      if (i == 4) check("t5_bubble", 64'(valid_ID), 64'h0);
      @(negedge clk);
    end
    ready_low = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_gap", 64'(valid_ID), 64'h0);
    @(negedge clk); expect_if("t5_resume", 1'b1, 64'h20);

    // Latency 2: one-cycle reset mid-stream with two outstanding.
    lat_min = 2; lat_max = 2;
    do_reset(1);
    repeat (6) @(negedge clk);
    expect_if("t6_pre", 1'b1, 64'h8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_valid", 64'(valid_ID), 64'h0);
    check("t6_pc", pc_ID, 64'h0);
    check("t6_instr", 64'(instruction_ID), 64'h0);
    check("t6_addr", imem_addr, 64'h0);
    check("t6_req", 64'(imem_req), 64'h1);
    repeat (3) @(negedge clk);
    check("t6_gap", 64'(valid_ID), 64'h0);
    @(negedge clk); expect_if("t6_first", 1'b1, 64'h0);

    // Randomized phase.
    lat_min = 1; lat_max = 4; rand_ready = 1'b1;
    do_reset(1);
    n_pop = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      stall_ID = ($urandom_range(0, 4) == 0);
      PCSrc_MEM = ($urandom_range(0, 39) == 0);
      BranchTarget_MEM = 64'($urandom_range(0, 65535)) << 2;
    end
    @(negedge clk);
    reset = 1'b0;
    stall_ID = 1'b0;
    PCSrc_MEM = 1'b0;
    repeat (20) @(negedge clk);
    check("rand_progress", 64'(n_pop > 200), 64'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
